mux_2to1_1bit_data: RTL and testbench
=====================================

// Module: mux_2to1_1bit_data
// PURPOSE
//   Single-bit 2-to-1 multiplexer for the data-routing library.
//   Output c selects input a when sel=0 and input b when sel=1.
//   c is purely combinational (dataflow).
//   A registered copy, c_q, is provided for pipelined consumers; it uses one clock and
//   a synchronous, active-low reset.
// PARAMETERS
//   RST_VAL  1'b0  value loaded into c_q while rst_n is low at a rising clk edge
// PORTS
//   clk    in   1  single clock; only c_q is sampled on its rising edge
//   rst_n  in   1  reset, synchronous, active-low; affects c_q only
//   a      in   1  data input 0, selected when sel=0
//   b      in   1  data input 1, selected when sel=1
//   sel    in   1  select: 0 -> a, 1 -> b
//   c      out  1  combinational mux output
//   c_q    out  1  registered mux output
// BEHAVIOUR
//   - Interface: one clock; reset is synchronous and active-low.
//   - c = sel ? b : a
//     - Zero-cycle latency; continuous assignment, no clock or reset dependency.
//     - Must settle within the same timestep that any input changes.
//   - c_q, at each rising clk edge:
//     - if rst_n==0: c_q <= RST_VAL
//     - else: c_q <= (sel ? b : a)
//     - Latency is 1 cycle relative to c.
//   - Reset:
//     - c_q takes RST_VAL only at a clock edge.
//     - An asynchronous assertion of rst_n does not change c_q until the next edge.
//     - Deasserting rst_n mid-operation: the first edge with rst_n==1 loads the current mux value.
//     - c is never affected by rst_n.
//   - Truth table for c (sel,a,b -> c): 0xx -> a; 1xx -> b. No other decoding.
//   - X/Z handling:
//     - If sel is X, c follows standard conditional-operator semantics: c=a when a==b, else X.
//     - No special masking is performed.
//   - No state other than the c_q flop. No handshake.
//   - c_q power-up value before the first reset edge is undefined.
// TESTING
//   1. sel=0, sweep (a,b)=00,01,10,11, hold 30 time units each -> c=0,0,1,1 (c follows a).
//   2. sel=1, sweep (a,b)=00,01,10,11, hold 30 time units each -> c=0,1,0,1 (c follows b).
//   3. a=1, b=0, toggle sel 0->1->0 with no clock running -> c goes 1->0->1 immediately.
//   4. rst_n=0 for 2 edges with a=b=sel=1 -> c_q=0 (RST_VAL), while c=1 throughout.
//   5. rst_n=1, a=1, b=0, sel=0, then sel=1 just after an edge -> c_q=1 for that cycle,
//      then 0 after the next edge.
//   6. Assert rst_n=0 between edges with c_q=1 -> c_q stays 1 until the next rising edge,
//      then becomes 0.

Source files
------------

// File: rtl/mux_2to1_1bit_data.sv
// Purpose: single-bit 2:1 data mux (c = sel ? b : a) plus a registered copy c_q.
// Latency: c is combinational (0 cycles); c_q lags c by 1 clk cycle.
// Backpressure: none; no handshake, output is valid every cycle.
module mux_2to1_1bit_data #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic c,
  output logic c_q
);

  // Dataflow select. A plain conditional keeps the X-merge behaviour when
  // sel is unknown (a==b gives a, otherwise X) with no extra masking.
  assign c = sel ? b : a;

  // Pipelined copy for downstream consumers; reset only acts on a clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_q <= RST_VAL;
    end else begin
      c_q <= c;
    end
  end

endmodule

// File: tb/tb_mux_2to1_1bit_data.sv
module tb_mux_2to1_1bit_data;

  logic clk;
  logic clk_en;
  logic rst_n;
  logic a;
  logic b;
  logic sel;
  logic c;
  logic c_q;

  int n_cmp;
  int n_err;

  mux_2to1_1bit_data #(.RST_VAL(1'b0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .sel  (sel),
    .c    (c),
    .c_q  (c_q)
  );

  // Gated free-running clock so a section can run with the clock stopped.
  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Wait for the next rising edge, then step off it before sampling.
  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] ab;
  logic [3:0] exp_sel0;
  logic [3:0] exp_sel1;

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    clk_en   = 1'b1;
    rst_n    = 1'b0;
    a        = 1'b1;
    b        = 1'b1;
    sel      = 1'b1;
    // index = {a,b}; sel=0 follows a, sel=1 follows b
    exp_sel0 = 4'b1100;
    exp_sel1 = 4'b1010;

    // Reset held for two edges with all inputs high: c_q=RST_VAL, c stays 1.
    #2;
    edge_settle();
    chk("rst_edge1_cq", c_q, 1'b0);
    chk("rst_edge1_c", c, 1'b1);
    edge_settle();
    chk("rst_edge2_cq", c_q, 1'b0);
    chk("rst_edge2_c", c, 1'b1);

    // sel=0 sweep: c follows a.
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ab = i[1:0];
      a  = ab[1];
      b  = ab[0];
      #1;
      chk($sformatf("sel0_ab%0d%0d", ab[1], ab[0]), c, exp_sel0[i]);
      #29;
    end

    // sel=1 sweep: c follows b.
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ab = i[1:0];
      a  = ab[1];
      b  = ab[0];
      #1;
      chk($sformatf("sel1_ab%0d%0d", ab[1], ab[0]), c, exp_sel1[i]);
      #29;
    end

    // Clock stopped: c must track sel immediately.
    clk_en = 1'b0;
    a      = 1'b1;
    b      = 1'b0;
    sel    = 1'b0;
    #1;
    chk("noclk_sel0", c, 1'b1);
    sel = 1'b1;
    #1;
    chk("noclk_sel1", c, 1'b0);
    sel = 1'b0;
    #1;
    chk("noclk_sel0_again", c, 1'b1);
    clk_en = 1'b1;
    #7;

    // Out of reset, c_q lags c by one edge.
    rst_n = 1'b1;
    a     = 1'b1;
    b     = 1'b0;
    sel   = 1'b0;
    edge_settle();
    chk("pipe_cq_loaded", c_q, 1'b1);
    sel = 1'b1;
    #1;
    chk("pipe_c_now_b", c, 1'b0);
    chk("pipe_cq_held", c_q, 1'b1);
    edge_settle();
    chk("pipe_cq_next", c_q, 1'b0);

    // Reset asserted between edges does not touch c_q until the next edge.
    sel = 1'b0;
    edge_settle();
    chk("midrst_cq_pre", c_q, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_cq_hold", c_q, 1'b1);
    chk("midrst_c_unaff", c, 1'b1);
    edge_settle();
    chk("midrst_cq_edge", c_q, 1'b0);

    // Releasing reset: first edge with rst_n=1 loads the current mux value.
    rst_n = 1'b1;
    edge_settle();
    chk("rel_cq_load", c_q, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
